trigger_word_decoder: RTL and testbench
=======================================

# trigger_word_decoder

Receive-side companion to the serialized trigger-word transmitter. Consumes the 8-bit parallel words delivered each fabric clock by a 1:8 input deserializer on the LVDS trigger link and finds the bit offset of the transmitted stream. It decodes the four-code trigger sequence (0xF0, 0x81, 0x88, 0xAA) into token pulses, a sync pulse, lock status and error counts. It sits between the deserializer and the trigger-handling logic of the receiving board.

## Interface
- MAX_ERRORS, 4: consecutive code errors while locked that force return to HUNT (range 1–15)
- ERR_WIDTH, 16: width of error_count
- clock  input  1  fabric clock, the deserializer CLKDIV domain (125 MHz); all logic on posedge
- reset_n  input  1  synchronous, active-low reset
- word_in  input  8  deserialized word; bit 7 = earliest received bit
- token_valid  output  1  one-cycle pulse: a known code was decoded
- token  output  2  decoded code: 0=0xF0, 1=0x81, 2=0x88, 3=0xAA; held between pulses
- sync  output  1  one-cycle pulse, coincident with token_valid when token=0
- seq_error  output  1  one-cycle pulse: known code decoded out of sequence
- code_error  output  1  one-cycle pulse: nonzero word matching no code
- locked  output  1  high in LOCKED state
- bit_offset  output  3  alignment offset in use
- error_count  output  ERR_WIDTH  saturating count of seq_error + code_error events

## Operation
- Window: prev_word registered each cycle; w = {prev_word, word_in} (16 bits); aligned word at offset k = w[15-k -: 8], k = 0..7.
- States: HUNT, LOCKED.
- HUNT: each cycle test all eight offsets for exactly 0xF0; on any match pick lowest k, load bit_offset=k, set expected=1, emit token_valid/sync with token=0, go LOCKED, clear consecutive-error counter. No other outputs pulse in HUNT.
- LOCKED: aligned word a = w at bit_offset, registered.
  - a=0x00: idle, no pulse.
  - a is a known code equal to expected: token_valid, token=code index, sync if index 0; expected <= index+1 (mod 4); consecutive errors cleared.
  - a is a known code not equal to expected: token_valid + seq_error; expected <= index+1; consecutive errors cleared.
  - a nonzero and not a known code: code_error only; consecutive errors +1; at MAX_ERRORS go HUNT same cycle (locked falls next cycle), bit_offset held.
- error_count increments on each seq_error or code_error pulse, saturates at all-ones, never wraps; cleared only by reset.
- Reset (any cycle, including mid-lock): state HUNT, prev_word=0, expected=0, all outputs 0, token=0, bit_offset=0, error_count=0.

## Timing
- word_in sampled on edge N; code fully contained in {word(N-1), word(N)} yields its output pulse registered at edge N+1 (one clock after the completing word).
- HUNT→LOCKED and the first sync pulse occur on the same edge; locked high from that edge.
- A code straddling two words (k≠0) completes on the second word; codes in consecutive cycles produce pulses in consecutive cycles.
- Reset dominates all other events on the same edge; outputs at reset values on the edge after reset_n sampled low.
- No backpressure; every cycle is processed.

## Configuration
- TRIGGER_WORD_DECODER_ERROR_COUNT_EN defined: error_count counter implemented as above.
- Not defined: error_count tied to 0; seq_error/code_error pulses and MAX_ERRORS unlock logic unchanged.

## Test plan
- Reset: hold reset_n=0 3 cycles with word_in=0xFF -> all outputs 0, locked=0, bit_offset=0.
- Aligned lock: idle 0x00, then 0xF0,0x00,0x81,0x00,0x88,0x00,0xAA -> locked, bit_offset=0, tokens 0,1,2,3, sync only with token 0, no errors.
- Offset 3: stream shifted 3 bits late (0xF0 arrives as 0x1E,0x00; 0x81 as 0x10,0x20) -> bit_offset=3, tokens 0,1 decoded one cycle after second word.
- Sequence error: locked, expected=1, send 0x88 -> token_valid token=2, seq_error=1, error_count=1; then 0xAA -> no error.
- Loss of lock: locked, send 0x55 four times -> four code_error pulses, locked=0 after fourth, error_count=4; then 0xF0 relocks.
- Saturation/reset mid-lock: ERR_WIDTH=2, force 5 errors -> error_count=3; assert reset_n=0 while locked -> locked=0, error_count=0 next edge.

Source files
------------

// File: rtl/trigger_word_decoder.sv
// trigger_word_decoder: aligns a 1:8 deserialized LVDS trigger stream and decodes the F0/81/88/AA code sequence.
// Optional error counter enabled by defining TRIGGER_WORD_DECODER_ERROR_COUNT_EN.
module trigger_word_decoder #(
   parameter int MAX_ERRORS = 4,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [7:0]           word_in,
   output logic                 token_valid,
   output logic [1:0]           token,
   output logic                 sync,
   output logic                 seq_error,
   output logic                 code_error,
   output logic                 locked,
   output logic [2:0]           bit_offset,
   output logic [ERR_WIDTH-1:0] error_count
);
   typedef enum logic {HUNT, LOCKED} state_t;
   localparam logic [3:0] MAX_E = 4'(MAX_ERRORS);
   state_t      r_state, w_next_state;
   logic [7:0]  r_prev;
   logic [15:0] r_win;
   logic [1:0]  r_expected, w_expected, w_idx, w_token;
   logic [3:0]  r_cerr, w_cerr, w_cerr_inc;
   logic [15:0] w_shift;
   logic [7:0]  w_aligned;
   logic        w_hit, w_known, w_hunt, w_tv, w_sync, w_seq, w_code;
   logic [2:0]  w_hit_k, w_offset;
   assign w_hunt     = (r_state == HUNT);
   assign w_shift    = r_win << bit_offset;
   assign w_aligned  = w_shift[15:8];
   assign w_known    = (w_aligned == 8'hF0) || (w_aligned == 8'h81) || (w_aligned == 8'h88) || (w_aligned == 8'hAA);
   assign w_idx      = (w_aligned == 8'h81) ? 2'd1 : (w_aligned == 8'h88) ? 2'd2 : (w_aligned == 8'hAA) ? 2'd3 : 2'd0;
   assign w_cerr_inc = r_cerr + 4'd1;
   assign locked     = (r_state == LOCKED);
   // search every bit offset of the window for the sync code; descending loop leaves the lowest offset
   always_comb begin
      w_hit   = 1'b0;
      w_hit_k = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (r_win[15-k -: 8] == 8'hF0) begin
            w_hit   = 1'b1;
            w_hit_k = 3'(k);
         end
      end
   end
   // state register
   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= HUNT;
      else          r_state <= w_next_state;
   end
   // next state: lock on sync code, drop after too many consecutive bad codes
   always_comb begin
      w_next_state = w_hunt ? (w_hit ? LOCKED : HUNT) : ((w_code && w_cerr_inc >= MAX_E) ? HUNT : LOCKED);
   end
   // next values of pulses, token, sequence tracking and alignment
   always_comb begin
      w_tv       = w_hunt ? w_hit : w_known;
      w_token    = w_hunt ? (w_hit ? 2'd0 : token) : (w_known ? w_idx : token);
      w_sync     = w_tv && (w_token == 2'd0);
      w_seq      = !w_hunt && w_known && (w_idx != r_expected);
      w_code     = !w_hunt && (w_aligned != 8'h00) && !w_known;
      w_expected = w_hunt ? (w_hit ? 2'd1 : r_expected) : (w_known ? w_idx + 2'd1 : r_expected);
      w_cerr     = w_hunt ? (w_hit ? 4'd0 : r_cerr) : (w_known ? 4'd0 : (w_code ? w_cerr_inc : r_cerr));
      w_offset   = (w_hunt && w_hit) ? w_hit_k : bit_offset;
   end
   // window, tracking state and registered outputs
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_prev      <= 8'h00;
         r_win       <= 16'h0000;
         r_expected  <= 2'd0;
         r_cerr      <= 4'd0;
         token_valid <= 1'b0;
         token       <= 2'd0;
         sync        <= 1'b0;
         seq_error   <= 1'b0;
         code_error  <= 1'b0;
         bit_offset  <= 3'd0;
      end else begin
         r_prev      <= word_in;
         r_win       <= {r_prev, word_in};
         r_expected  <= w_expected;
         r_cerr      <= w_cerr;
         token_valid <= w_tv;
         token       <= w_token;
         sync        <= w_sync;
         seq_error   <= w_seq;
         code_error  <= w_code;
         bit_offset  <= w_offset;
      end
   end
`ifdef TRIGGER_WORD_DECODER_ERROR_COUNT_EN
   logic [ERR_WIDTH-1:0] r_err_cnt;
   // saturating count of sequence and code errors
   always_ff @(posedge clock) begin
      if (!reset_n)                           r_err_cnt <= '0;
      else if ((w_seq || w_code) && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
   end
   assign error_count = r_err_cnt;
`else
   assign error_count = '0;
`endif
endmodule

// File: tb/tb_trigger_word_decoder.sv
// tb_trigger_word_decoder: directed vectors with hand-computed expectations for trigger_word_decoder.
module tb_trigger_word_decoder;
`ifdef TRIGGER_WORD_DECODER_ERROR_COUNT_EN
   localparam bit EC_EN = 1'b1;
`else
   localparam bit EC_EN = 1'b0;
`endif
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] word_in = 8'h00;
   logic       token_valid, sync, seq_error, code_error, locked;
   logic [1:0] token;
   logic [2:0] bit_offset;
   logic [1:0] error_count;
   int n_chk = 0;
   int n_bad = 0;
   trigger_word_decoder #(.MAX_ERRORS(4), .ERR_WIDTH(2)) dut (
      .clock(clock), .reset_n(reset_n), .word_in(word_in),
      .token_valid(token_valid), .token(token), .sync(sync),
      .seq_error(seq_error), .code_error(code_error), .locked(locked),
      .bit_offset(bit_offset), .error_count(error_count)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic step(input logic [7:0] w, input int tv, input int tok, input int sy, input int se,
                       input int ce, input int lk, input int off, input int ec);
      word_in = w;
      @(posedge clock);
      #1;
      chk("token_valid", int'(token_valid), tv);
      chk("token", int'(token), tok);
      chk("sync", int'(sync), sy);
      chk("seq_error", int'(seq_error), se);
      chk("code_error", int'(code_error), ce);
      chk("locked", int'(locked), lk);
      chk("bit_offset", int'(bit_offset), off);
      chk("error_count", int'(error_count), EC_EN ? ec : 0);
   endtask
   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) step(8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      step(8'hF0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      step(8'h81, 1, 0, 1, 0, 0, 1, 0, 0);
      step(8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
      step(8'h88, 1, 1, 0, 0, 0, 1, 0, 0);
      step(8'h00, 0, 1, 0, 0, 0, 1, 0, 0);
      step(8'hAA, 1, 2, 0, 0, 0, 1, 0, 0);
      step(8'h00, 0, 2, 0, 0, 0, 1, 0, 0);
      step(8'h00, 1, 3, 0, 0, 0, 1, 0, 0);
      step(8'hF0, 0, 3, 0, 0, 0, 1, 0, 0);
      step(8'h00, 0, 3, 0, 0, 0, 1, 0, 0);
      step(8'h88, 1, 0, 1, 0, 0, 1, 0, 0);
      step(8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
      step(8'hAA, 1, 2, 0, 1, 0, 1, 0, 1);
      step(8'h00, 0, 2, 0, 0, 0, 1, 0, 1);
      step(8'h00, 1, 3, 0, 0, 0, 1, 0, 1);
      step(8'h55, 0, 3, 0, 0, 0, 1, 0, 1);
      step(8'h55, 0, 3, 0, 0, 0, 1, 0, 1);
      step(8'h55, 0, 3, 0, 0, 1, 1, 0, 2);
      step(8'h55, 0, 3, 0, 0, 1, 1, 0, 3);
      step(8'h00, 0, 3, 0, 0, 1, 1, 0, 3);
      step(8'h00, 0, 3, 0, 0, 1, 0, 0, 3);
      step(8'hF0, 0, 3, 0, 0, 0, 0, 0, 3);
      step(8'h00, 0, 3, 0, 0, 0, 0, 0, 3);
      step(8'h00, 1, 0, 1, 0, 0, 1, 0, 3);
      reset_n = 1'b0;
      step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      step(8'h55, 0, 0, 0, 0, 0, 0, 0, 0);
      step(8'h1E, 0, 0, 0, 0, 0, 0, 0, 0);
      step(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      step(8'h10, 1, 0, 1, 0, 0, 1, 3, 0);
      step(8'h20, 0, 0, 0, 0, 0, 1, 3, 0);
      step(8'h00, 1, 1, 0, 0, 0, 1, 3, 0);
      step(8'h00, 0, 1, 0, 0, 0, 1, 3, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
